// File: rtl/mult_control.sv
// mult_control -- sequencing FSM for the 8-bit shift-add multiplier datapath.
//
// Drives the A/B shift register pair, the X sign flop and the 9-bit add/sub
// unit through N_BITS add-then-shift iterations. The last iteration subtracts
// instead of adding, which leaves a signed (2's complement) product in {X,A,B}.
//
// Build option:
//   MULT_AUTO_CLEAR_EN  defined   -> every run starts with a CLR state that
//                                    zeroes A and X, so runs are independent.
//                       undefined -> no CLR state; A and X keep their prior
//                                    contents and a new run accumulates unless
//                                    ClearA_LoadB is used first.
//
// Parameters:
//   N_BITS        multiplier width = number of add/shift iterations (>= 2)
//
// Ports:
//   Clk           in   clock, rising edge
//   Reset         in   synchronous, active-high reset
//   Run           in   start request (level, already synchronised)
//   ClearA_LoadB  in   load B from switches, clear A and X (level)
//   M             in   current multiplier LSB (B[0])
//   ResetA        out  clear A register
//   Ld_A          out  load A with adder result
//   Ld_B          out  load B with switch value S
//   Shift_En      out  shift {X,A,B} right by one
//   Clr_X         out  clear X sign flop
//   Ld_X          out  load X with adder bit 8
//   Sub           out  adder function: 1 = A - S, 0 = A + S
//   Busy          out  multiply in progress
//   Done          out  product valid, held until Run is released

module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic ResetA,
  output logic Ld_A,
  output logic Ld_B,
  output logic Shift_En,
  output logic Clr_X,
  output logic Ld_X,
  output logic Sub,
  output logic Busy,
  output logic Done
);

  localparam int              CNT_W    = $clog2(N_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
`ifdef MULT_AUTO_CLEAR_EN
    , S_CLR = 3'd1
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_iter_s;

  assign last_iter_s = (cnt_q == CNT_LAST);

  // Next-state, iteration counter and output decode. Outputs are decoded
  // from the current state (plus M and ClearA_LoadB) because the datapath
  // must act in the same cycle the state is entered. While Reset is high
  // every output is forced low so the register unit is left untouched.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ResetA   = 1'b0;
    Ld_A     = 1'b0;
    Ld_B     = 1'b0;
    Shift_En = 1'b0;
    Clr_X    = 1'b0;
    Ld_X     = 1'b0;
    Sub      = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;

    if (Reset) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Loading B has priority over starting a run in the same cycle.
          if (ClearA_LoadB) begin
            ResetA = 1'b1;
            Ld_B   = 1'b1;
            Clr_X  = 1'b1;
          end else if (Run) begin
            cnt_d = '0;
`ifdef MULT_AUTO_CLEAR_EN
            state_d = S_CLR;
`else
            state_d = S_ADD;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end

`ifdef MULT_AUTO_CLEAR_EN
        S_CLR: begin
          ResetA  = 1'b1;
          Clr_X   = 1'b1;
          Busy    = 1'b1;
          state_d = S_ADD;
        end
`endif

        S_ADD: begin
          // Only accumulate when the current multiplier bit is set; the
          // final (sign) bit has negative weight, hence the subtract.
          Busy    = 1'b1;
          Ld_A    = M;
          Ld_X    = M;
          Sub     = last_iter_s;
          state_d = S_SHIFT;
        end

        S_SHIFT: begin
          Busy     = 1'b1;
          Shift_En = 1'b1;
          if (last_iter_s) begin
            state_d = S_HOLD;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
            state_d = S_ADD;
          end
        end

        S_HOLD: begin
          // Stay here while Run is held so a level-held Run cannot
          // retrigger another multiply.
          Done = 1'b1;
          if (!Run) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
// tb_mult_control -- self-checking bench for mult_control (N_BITS = 8).
// A small register-unit model (A, B, X, 9-bit add/sub) is driven by the DUT
// control outputs; final products are compared against signed integer
// multiplication, and per-cycle control outputs against the expected
// add/shift timeline derived from the multiplier bits.

module tb_mult_control;

  localparam int N = 8;
`ifdef MULT_AUTO_CLEAR_EN
  localparam int CLR_EXTRA = 1;
`else
  localparam int CLR_EXTRA = 0;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic ClearA_LoadB = 1'b0;
  logic M;
  logic ResetA, Ld_A, Ld_B, Shift_En, Clr_X, Ld_X, Sub, Busy, Done;

  // Register-unit model
  logic [7:0] a_r = 8'h00;
  logic [7:0] b_r = 8'h00;
  logic       x_r = 1'b0;
  logic [7:0] s_sw = 8'h00;
  logic [8:0] sum_s;
  logic [8:0] outs_s;

  int tests = 0;
  int fails = 0;

  mult_control #(.N_BITS(N)) dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .ResetA(ResetA), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
    .Clr_X(Clr_X), .Ld_X(Ld_X), .Sub(Sub), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  assign M      = b_r[0];
  assign sum_s  = Sub ? ({a_r[7], a_r} - {s_sw[7], s_sw})
                      : ({a_r[7], a_r} + {s_sw[7], s_sw});
  assign outs_s = {ResetA, Ld_A, Ld_B, Shift_En, Clr_X, Ld_X, Sub, Busy, Done};

  // Register unit reacting to the control strobes.
  always @(posedge Clk) begin
    if (ResetA)        a_r <= 8'h00;
    else if (Ld_A)     a_r <= sum_s[7:0];
    else if (Shift_En) a_r <= {x_r, a_r[7:1]};
    if (Ld_B)          b_r <= s_sw;
    else if (Shift_En) b_r <= {a_r[0], b_r[7:1]};
    if (Clr_X)         x_r <= 1'b0;
    else if (Ld_X)     x_r <= sum_s[8];
  end

  function automatic logic [8:0] ev(input logic rsta, input logic lda, input logic ldb,
                                    input logic sh, input logic clrx, input logic ldx,
                                    input logic sub, input logic busy, input logic done);
    return {rsta, lda, ldb, sh, clrx, ldx, sub, busy, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One-cycle ClearA_LoadB pulse loading B from the switches.
  task automatic load_b(input logic [7:0] bv);
    s_sw = bv;
    ClearA_LoadB = 1'b1;
    #1 chk("load_strobes", 32'(outs_s), 32'(ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
    step();
    ClearA_LoadB = 1'b0;
  endtask

  // Raise Run in IDLE and check every control output cycle by cycle until Done.
  task automatic run_timeline(input logic [7:0] bm, input string tag);
    logic [8:0] e;
    int j;
    int i;
    Run = 1'b1;
    for (int k = 0; k <= 2 * N + 1 + CLR_EXTRA; k++) begin
      if (k == 0) begin
        e = 9'd0;
      end else if (CLR_EXTRA == 1 && k == 1) begin
        e = ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      end else if (k <= 2 * N + CLR_EXTRA) begin
        j = k - 1 - CLR_EXTRA;
        i = j / 2;
        if (j % 2 == 0)
          e = ev(1'b0, bm[i], 1'b0, 1'b0, 1'b0, bm[i], (i == N - 1), 1'b1, 1'b0);
        else
          e = ev(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        e = ev(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      #1 chk($sformatf("%s_cyc%0d", tag, k), 32'(outs_s), 32'(e));
      step();
    end
  endtask

  // Drop Run in HOLD: Done still up that cycle, then back to IDLE.
  task automatic release_run(input string tag);
    Run = 1'b0;
    #1 chk({tag, "_done_at_release"}, 32'(Done), 32'd1);
    step();
    #1 chk({tag, "_idle_after"}, 32'(outs_s), 32'd0);
  endtask

  // Full multiply: load B, run, compare {X,A,B} with signed product.
  task automatic multiply(input logic [7:0] sv, input logic [7:0] bv, input string tag);
    byte signed sa;
    byte signed sb;
    int p;
    logic [16:0] exp17;
    load_b(bv);
    s_sw = sv;
    run_timeline(b_r, tag);
    sa = sv;
    sb = bv;
    p = int'(sa) * int'(sb);
    exp17 = p[16:0];
    chk({tag, "_product"}, 32'({x_r, a_r, b_r}), 32'(exp17));
    release_run(tag);
  endtask

  initial begin
    logic [7:0] rs;
    logic [7:0] rb;

    // Reset held two cycles with both requests active: Reset must win.
    Reset = 1'b1;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    step();
    chk("reset_cyc0", 32'(outs_s), 32'd0);
    step();
    chk("reset_cyc1", 32'(outs_s), 32'd0);
    Reset = 1'b0;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    #1 chk("idle_after_reset", 32'(outs_s), 32'd0);
    step();

    // ClearA_LoadB beats Run in the same IDLE cycle; strobes last one cycle.
    s_sw = 8'h07;
    ClearA_LoadB = 1'b1;
    Run = 1'b1;
    #1 chk("clr_prio_strobes", 32'(outs_s), 32'(ev(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)));
    step();
    ClearA_LoadB = 1'b0;
    Run = 1'b0;
    #1 chk("clr_prio_no_start", 32'(outs_s), 32'd0);
    chk("clr_prio_b_loaded", 32'(b_r), 32'h07);
    step();

    // Directed products, including the sign-bit boundaries.
    multiply(8'h3B, 8'h07, "p_3b_07");
    multiply(8'h3B, 8'hF9, "p_3b_f9");
    multiply(8'h80, 8'h80, "p_80_80");
    multiply(8'h7F, 8'h80, "p_7f_80");
    multiply(8'hFF, 8'h00, "p_ff_00");
    multiply(8'h80, 8'h7F, "p_80_7f");

    // Randomised products.
    for (int r = 0; r < 8; r++) begin
      rs = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      multiply(rs, rb, $sformatf("rnd%0d", r));
    end

    // Done with Run held: no restart; release then restart.
    load_b(8'h5A);
    s_sw = 8'h13;
    run_timeline(b_r, "hold");
    for (int c = 0; c < 10; c++) begin
      #1 chk($sformatf("hold_nobusy%0d", c), 32'({Busy, Done}), 32'b01);
      step();
    end
    release_run("hold");
    run_timeline(b_r, "restart");
    release_run("restart");

    // Reset in the middle of a run, then a full run must still be correct.
    load_b(8'h55);
    s_sw = 8'h3B;
    Run = 1'b1;
    for (int k = 0; k < 7; k++) step();
    Reset = 1'b1;
    #1 chk("midrun_reset_outs", 32'(outs_s), 32'd0);
    step();
    Reset = 1'b0;
    Run = 1'b0;
    #1 chk("midrun_idle_after", 32'(outs_s), 32'd0);
    step();
    multiply(8'h3B, 8'h07, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
